aud_rmm_burst: RTL
==================

Name: aud_rmm_burst

Overview:
- Parametrised burst sequencer for AUD RMM (remote memory monitor) accesses.
- Sits between host register logic and the single-access RMM engine.
- Runs an N-transfer read or write burst with byte/word/long sizing, optional fixed address, error retry, timeout and abort.
- Owns its own write-data FIFO and read-data FIFO, so software no longer paces individual accesses.

Parameters:
ADDR_W, 32, RMM address width; address arithmetic wraps modulo 2^ADDR_W
FIFO_AW, 4, FIFO address width; each FIFO holds 2^FIFO_AW 32-bit words
LEN_W, 16, width of burst length and transfer counter
TMO_W, 12, timeout counter width; timeout fires after 2^TMO_W-1 cycles in one wait state
MAX_RETRY, 2, re-issues of a failed access before the burst aborts

Ports:
clk_sys_i  in  1  system clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle burst start; ignored while busy_o=1
abort_i  in  1  abort current burst
dir_i  in  1  1=write burst, 0=read burst; sampled at start
size_i  in  2  00=byte, 01=word, 10=long, 11 treated as long; sampled at start
addr_i  in  ADDR_W  start address; sampled at start
len_i  in  LEN_W  transfer count; sampled at start
inc_dis_i  in  1  1=fixed address; sampled at start
fifo_clr_i  in  1  synchronous flush of both FIFOs and clear of ovf/und flags
busy_o  out  1  burst in progress
done_o  out  1  one-cycle end-of-burst pulse (success or error)
err_o  out  1  burst ended in error; held until next accepted start
err_code_o  out  2  00 none, 01 RMM error after retries, 10 timeout, 11 abort
xfer_cnt_o  out  LEN_W  completed transfers in current/last burst
wf_dat_i  in  32  write-FIFO data
wf_we_i  in  1  write-FIFO push
wf_full_o  out  1  write FIFO full
wf_count_o  out  FIFO_AW+1  write-FIFO occupancy
rf_dat_o  out  32  read-FIFO head word (first-word fall-through)
rf_re_i  in  1  read-FIFO pop
rf_empty_o  out  1  read FIFO empty
rf_count_o  out  FIFO_AW+1  read-FIFO occupancy
ovf_o  out  1  sticky: push to a full FIFO
und_o  out  1  sticky: pop from an empty FIFO
rmm_addr_o  out  ADDR_W  RMM access address
rmm_data_o  out  32  RMM write data
rmm_size_o  out  2  RMM access size
rmm_we_o  out  1  one-cycle write-issue strobe
rmm_re_o  out  1  one-cycle read-issue strobe
rmm_data_i  in  32  RMM read data; valid when rmm_idle_i rises
rmm_err_i  in  1  RMM error; sampled while rmm_idle_i=0
rmm_idle_i  in  1  RMM engine idle

Behaviour:
Reset:
- rst_i clears all outputs, counters, FIFOs and sticky flags to 0; FSM goes to IDLE.
- Reset asserted mid-burst abandons the burst; no done_o pulse.

FSM states:
- IDLE: on start_i, latch the burst parameters, clear err_o/err_code_o/xfer_cnt_o, set busy_o.
  - len_i=0: go to DONE, no RMM access.
  - Otherwise: go to ISSUE.
- ISSUE, write burst: stall while the write FIFO is empty. When not empty: pop the head into rmm_data_o, pulse rmm_we_o, go to WAIT_BUSY.
- ISSUE, read burst: stall while the read FIFO is full. When not full: pulse rmm_re_o, go to WAIT_BUSY.
- ISSUE stalls do not run the timeout.
- WAIT_BUSY: wait for rmm_idle_i=0, then go to WAIT_IDLE.
- WAIT_IDLE: wait for rmm_idle_i=1.
  - Latch an error flag if rmm_err_i=1 on any cycle in this state.
  - On idle with no error: a read pushes rmm_data_i into the read FIFO, masked to size (byte: [7:0], word: [15:0], upper bits zero). Then go to NEXT.
  - On idle with error: if the retry count is below MAX_RETRY, increment it and return to ISSUE. A write retry reuses the held rmm_data_o and does not pop the FIFO. Otherwise end with err_code 01 and go to DONE.
- NEXT:
  - Increment xfer_cnt_o and clear the retry count.
  - Advance the address by 1/2/4 (byte/word/long) unless inc_dis_i was set; the address wraps.
  - If xfer_cnt equals len, go to DONE; otherwise go to ISSUE.
- DONE: pulse done_o, clear busy_o, go to IDLE.

Timeout and abort:
- Timeout counter runs in WAIT_BUSY and WAIT_IDLE and resets on each state entry.
- Timeout expiry: err_code 10, go to DONE.
- abort_i in any non-IDLE state: err_code 11, go to DONE next cycle. It has priority over timeout and error, and no issue strobe fires in that cycle.
- abort_i in IDLE: ignored.

Address and strobes:
- rmm_addr_o and rmm_size_o are stable from the ISSUE cycle until the access completes.
- rmm_we_o and rmm_re_o are never high together.

FIFOs:
- Synchronous, first-word fall-through, 2^FIFO_AW deep.
- Push when full: data dropped, ovf_o set. Pop when empty: no change, und_o set.
- Simultaneous push and pop: both take effect (when full: pop only, push dropped).
- fifo_clr_i overrides same-cycle push/pop. During a burst it is allowed but its data effects are undefined.

Test Plan:
- Write burst: addr 0x1000, size long, len 3, FIFO preloaded A,B,C -> rmm_we_o at addresses 0x1000/0x1004/0x1008 with data A/B/C; done_o, err_o=0, xfer_cnt_o=3.
- Read burst: size byte, len 4, inc_dis_i=1 at 0xFFFF0000, RMM returns 0x123456AA -> read FIFO holds 4 × 0x000000AA, every address 0xFFFF0000.
- Address wrap: word reads from 0xFFFFFFFE, len 2 -> addresses 0xFFFFFFFE then 0x00000000.
- Error retry: rmm_err_i on the first 2 attempts of transfer 1, MAX_RETRY=2 -> third issue succeeds, same write data, no extra FIFO pop. With 3 failures -> err_code 01, xfer_cnt_o=0.
- Timeout and abort: rmm_idle_i held 0 -> err_code 10 after 4095 cycles. abort_i during WAIT_IDLE -> done_o next cycle, err_code 11.
- Boundaries: len 0 -> done_o one cycle after start, no strobes. 17 pushes (FIFO_AW=4) -> count 16, ovf_o=1. Read burst len 20 with no pops -> stalls in ISSUE at count 16 without timing out, resumes after pops.

Source files
------------

// File: rtl/aud_rmm_burst.sv
// aud_rmm_burst: burst sequencer between host register logic and the single-access RMM engine.
// Runs an N-transfer read or write burst (byte/word/long, optional fixed address) with error
// retry, wait-state timeout and abort. Owns a write-data FIFO (host -> RMM) and a read-data
// FIFO (RMM -> host), both first-word fall-through.
//
// Ports:
//   clk_sys_i, rst_i           clock, asynchronous active-high reset
//   start_i, abort_i           burst start (ignored while busy), burst abort
//   dir_i, size_i, addr_i,     burst parameters, sampled on an accepted start
//   len_i, inc_dis_i
//   fifo_clr_i                 flush both FIFOs and clear the ovf/und flags
//   busy_o, done_o, err_o,     burst status; err_o/err_code_o held until the next start
//   err_code_o, xfer_cnt_o
//   wf_*                       write-FIFO push side and status
//   rf_*                       read-FIFO pop side and status
//   ovf_o, und_o               sticky FIFO overflow / underflow
//   rmm_*                      RMM engine access interface

module aud_rmm_burst #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned TMO_W     = 12,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic              clk_sys_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              inc_dis_i,
  input  logic              fifo_clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [LEN_W-1:0]  xfer_cnt_o,
  input  logic [31:0]       wf_dat_i,
  input  logic              wf_we_i,
  output logic              wf_full_o,
  output logic [FIFO_AW:0]  wf_count_o,
  output logic [31:0]       rf_dat_o,
  input  logic              rf_re_i,
  output logic              rf_empty_o,
  output logic [FIFO_AW:0]  rf_count_o,
  output logic              ovf_o,
  output logic              und_o,
  output logic [ADDR_W-1:0] rmm_addr_o,
  output logic [31:0]       rmm_data_o,
  output logic [1:0]        rmm_size_o,
  output logic              rmm_we_o,
  output logic              rmm_re_o,
  input  logic [31:0]       rmm_data_i,
  input  logic              rmm_err_i,
  input  logic              rmm_idle_i
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  // Counter value on the (2^TMO_W-1)th cycle of a wait state.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RMM   = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitIdle,
    StNext,
    StDone
  } state_e;

  state_e             state_q;
  logic               dir_q;
  logic [1:0]         size_q;
  logic               inc_dis_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   xfer_cnt_q;
  logic [RTY_W-1:0]   retry_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               err_seen_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [1:0]         err_code_q;
  logic [31:0]        rmm_data_q;
  logic               rmm_we_q;
  logic               rmm_re_q;

  // Write FIFO
  logic [31:0]        wf_mem [DEPTH];
  logic [FIFO_AW-1:0] wf_wr_ptr_q;
  logic [FIFO_AW-1:0] wf_rd_ptr_q;
  logic [FIFO_AW:0]   wf_cnt_q;
  logic               wf_full;
  logic               wf_empty;
  logic               wf_do_push;
  logic               wf_pop;

  // Read FIFO
  logic [31:0]        rf_mem [DEPTH];
  logic [FIFO_AW-1:0] rf_wr_ptr_q;
  logic [FIFO_AW-1:0] rf_rd_ptr_q;
  logic [FIFO_AW:0]   rf_cnt_q;
  logic               rf_full;
  logic               rf_empty;
  logic               rf_push;
  logic               rf_do_push;
  logic               rf_do_pop;
  logic [31:0]        rf_push_dat;

  logic               ovf_q;
  logic               und_q;

  logic               tmo_fire;
  logic [ADDR_W-1:0]  addr_step;

  assign wf_full    = (wf_cnt_q == FULL_CNT);
  assign wf_empty   = (wf_cnt_q == '0);
  assign rf_full    = (rf_cnt_q == FULL_CNT);
  assign rf_empty   = (rf_cnt_q == '0);
  assign wf_do_push = wf_we_i && !wf_full;
  assign rf_do_push = rf_push && !rf_full;
  assign rf_do_pop  = rf_re_i && !rf_empty;
  assign tmo_fire   = (tmo_q == TMO_LAST);

  // FIFO strobes driven by the sequencer; the FSM below uses the same terms so the
  // data path and the state transitions always agree.
  always_comb begin
    wf_pop      = 1'b0;
    rf_push     = 1'b0;
    rf_push_dat = rmm_data_i;
    addr_step   = ADDR_W'(4);

    // A retried write reuses the held data word, so only the first attempt pops.
    if (state_q == StIssue && !abort_i && dir_q && retry_q == '0 && !wf_empty) begin
      wf_pop = 1'b1;
    end
    if (state_q == StWaitIdle && !abort_i && !tmo_fire && rmm_idle_i && !err_seen_q && !dir_q) begin
      rf_push = 1'b1;
    end

    case (size_q)
      2'b00: begin
        rf_push_dat = {24'b0, rmm_data_i[7:0]};
        addr_step   = ADDR_W'(1);
      end
      2'b01: begin
        rf_push_dat = {16'b0, rmm_data_i[15:0]};
        addr_step   = ADDR_W'(2);
      end
      default: begin
        rf_push_dat = rmm_data_i;
        addr_step   = ADDR_W'(4);
      end
    endcase
  end

  // FIFO storage carries no reset; emptiness is defined by the pointers and counts.
  always_ff @(posedge clk_sys_i) begin
    if (!fifo_clr_i && wf_do_push) begin
      wf_mem[wf_wr_ptr_q] <= wf_dat_i;
    end
    if (!fifo_clr_i && rf_do_push) begin
      rf_mem[rf_wr_ptr_q] <= rf_push_dat;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      wf_wr_ptr_q <= '0;
      wf_rd_ptr_q <= '0;
      wf_cnt_q    <= '0;
      rf_wr_ptr_q <= '0;
      rf_rd_ptr_q <= '0;
      rf_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
    end else if (fifo_clr_i) begin
      wf_wr_ptr_q <= '0;
      wf_rd_ptr_q <= '0;
      wf_cnt_q    <= '0;
      rf_wr_ptr_q <= '0;
      rf_rd_ptr_q <= '0;
      rf_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      if (wf_do_push) begin
        wf_wr_ptr_q <= wf_wr_ptr_q + 1'b1;
      end
      if (wf_pop) begin
        wf_rd_ptr_q <= wf_rd_ptr_q + 1'b1;
      end
      if (wf_do_push && !wf_pop) begin
        wf_cnt_q <= wf_cnt_q + 1'b1;
      end else if (!wf_do_push && wf_pop) begin
        wf_cnt_q <= wf_cnt_q - 1'b1;
      end

      if (rf_do_push) begin
        rf_wr_ptr_q <= rf_wr_ptr_q + 1'b1;
      end
      if (rf_do_pop) begin
        rf_rd_ptr_q <= rf_rd_ptr_q + 1'b1;
      end
      if (rf_do_push && !rf_do_pop) begin
        rf_cnt_q <= rf_cnt_q + 1'b1;
      end else if (!rf_do_push && rf_do_pop) begin
        rf_cnt_q <= rf_cnt_q - 1'b1;
      end

      if ((wf_we_i && wf_full) || (rf_push && rf_full)) begin
        ovf_q <= 1'b1;
      end
      if (rf_re_i && rf_empty) begin
        und_q <= 1'b1;
      end
    end
  end

  // Burst sequencer. done_q is raised on every transition into StDone, so the pulse
  // coincides with the single StDone cycle; busy_q drops as StDone exits.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      size_q     <= 2'b00;
      inc_dis_q  <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      xfer_cnt_q <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      err_seen_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      rmm_data_q <= '0;
      rmm_we_q   <= 1'b0;
      rmm_re_q   <= 1'b0;
    end else begin
      rmm_we_q <= 1'b0;
      rmm_re_q <= 1'b0;
      done_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            dir_q      <= dir_i;
            size_q     <= (size_i == 2'b11) ? 2'b10 : size_i;
            addr_q     <= addr_i;
            len_q      <= len_i;
            inc_dis_q  <= inc_dis_i;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            xfer_cnt_q <= '0;
            retry_q    <= '0;
            busy_q     <= 1'b1;
            if (len_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end

        StIssue: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ABORT;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else if (dir_q) begin
            if (retry_q != '0) begin
              rmm_we_q <= 1'b1;
              tmo_q    <= '0;
              state_q  <= StWaitBusy;
            end else if (wf_pop) begin
              rmm_data_q <= wf_mem[wf_rd_ptr_q];
              rmm_we_q   <= 1'b1;
              tmo_q      <= '0;
              state_q    <= StWaitBusy;
            end
          end else if (!rf_full) begin
            rmm_re_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= StWaitBusy;
          end
        end

        StWaitBusy: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ABORT;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else if (tmo_fire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else if (!rmm_idle_i) begin
            // The engine may flag an error in the very cycle it goes busy.
            err_seen_q <= rmm_err_i;
            tmo_q      <= '0;
            state_q    <= StWaitIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StWaitIdle: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ABORT;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else if (tmo_fire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else if (rmm_idle_i) begin
            if (!err_seen_q) begin
              state_q <= StNext;
            end else if (retry_q < RTY_W'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StIssue;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_RMM;
              state_q    <= StDone;
              done_q     <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (rmm_err_i) begin
              err_seen_q <= 1'b1;
            end
          end
        end

        StNext: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ABORT;
            state_q    <= StDone;
            done_q     <= 1'b1;
          end else begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
            retry_q    <= '0;
            if (!inc_dis_q) begin
              addr_q <= addr_q + addr_step;
            end
            if ((xfer_cnt_q + 1'b1) == len_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end

        // The burst is already ending here, so a late abort has nothing left to cancel.
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign xfer_cnt_o = xfer_cnt_q;
  assign wf_full_o  = wf_full;
  assign wf_count_o = wf_cnt_q;
  assign rf_dat_o   = rf_mem[rf_rd_ptr_q];
  assign rf_empty_o = rf_empty;
  assign rf_count_o = rf_cnt_q;
  assign ovf_o      = ovf_q;
  assign und_o      = und_q;
  assign rmm_addr_o = addr_q;
  assign rmm_data_o = rmm_data_q;
  assign rmm_size_o = size_q;
  assign rmm_we_o   = rmm_we_q;
  assign rmm_re_o   = rmm_re_q;

endmodule
